// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.
//   Owns the PC, issues reads to a synchronous instruction memory (data comes
//   back one cycle after the request), accepts redirects from the EX-stage
//   jump controller and holds fetch/decode under a hazard-unit stall without
//   losing or duplicating instructions.
//
// Ports
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   synchronous active-high reset
//   stall        in   1   hold IF and IF/ID
//   jump_flag    in   1   EX redirect request
//   jump_target  in   32  EX redirect address
//   imem_en      out  1   instruction memory read enable
//   imem_addr    out  32  instruction memory read address (word aligned)
//   imem_rdata   in   32  read data for the previous cycle's request
//   id_valid     out  1   IF/ID holds a live instruction
//   id_pc        out  32  PC of id_inst
//   id_inst      out  32  instruction to decode (NOP_INST when !id_valid)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    // Next sequential fetch address.
    logic [31:0] pc_reg,        pc_next;
    // Request issued in the previous cycle; its data is on imem_rdata now.
    logic        req_v_reg,     req_v_next;
    logic [31:0] req_pc_reg,    req_pc_next;
    // One-entry buffer catching the in-flight read when a stall arrives.
    logic        skid_v_reg,    skid_v_next;
    logic [31:0] skid_pc_reg,   skid_pc_next;
    logic [31:0] skid_inst_reg, skid_inst_next;
    // IF/ID register.
    logic        id_valid_reg,  id_valid_next;
    logic [31:0] id_pc_reg,     id_pc_next;
    logic [31:0] id_inst_reg,   id_inst_next;

    logic [31:0] addr_sel;

    // A redirect always issues, even under stall, so the target is not lost.
    assign addr_sel  = jump_flag ? jump_target : pc_reg;
    assign imem_addr = addr_sel & 32'hFFFF_FFFC;
    assign imem_en   = !rst && (jump_flag || !stall);

    assign id_valid  = id_valid_reg;
    assign id_pc     = id_pc_reg;
    assign id_inst   = id_inst_reg;

    always_comb begin
        pc_next        = pc_reg;
        req_v_next     = req_v_reg;
        req_pc_next    = req_pc_reg;
        skid_v_next    = skid_v_reg;
        skid_pc_next   = skid_pc_reg;
        skid_inst_next = skid_inst_reg;
        id_valid_next  = id_valid_reg;
        id_pc_next     = id_pc_reg;
        id_inst_next   = id_inst_reg;

        if (jump_flag) begin
            // Fetch the target now and drop everything older than it.
            req_v_next    = 1'b1;
            req_pc_next   = imem_addr;
            pc_next       = imem_addr + 32'd4;
            skid_v_next   = 1'b0;
            id_valid_next = 1'b0;
            id_inst_next  = NOP_INST;
        end else if (stall) begin
            // The memory will not hold its output, so park the returning
            // word in the skid buffer until decode can take it.
            if (req_v_reg) begin
                skid_v_next    = 1'b1;
                skid_pc_next   = req_pc_reg;
                skid_inst_next = imem_rdata;
            end
            req_v_next = 1'b0;
        end else begin
            req_v_next  = 1'b1;
            req_pc_next = pc_reg;
            pc_next     = pc_reg + 32'd4;
            // The skid entry is always older than any live request.
            if (skid_v_reg) begin
                id_valid_next = 1'b1;
                id_pc_next    = skid_pc_reg;
                id_inst_next  = skid_inst_reg;
                skid_v_next   = 1'b0;
            end else if (req_v_reg) begin
                id_valid_next = 1'b1;
                id_pc_next    = req_pc_reg;
                id_inst_next  = imem_rdata;
            end else begin
                id_valid_next = 1'b0;
                id_inst_next  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            req_v_reg     <= 1'b0;
            req_pc_reg    <= 32'd0;
            skid_v_reg    <= 1'b0;
            skid_pc_reg   <= 32'd0;
            skid_inst_reg <= NOP_INST;
            id_valid_reg  <= 1'b0;
            id_pc_reg     <= 32'd0;
            id_inst_reg   <= NOP_INST;
        end else begin
            pc_reg        <= pc_next;
            req_v_reg     <= req_v_next;
            req_pc_reg    <= req_pc_next;
            skid_v_reg    <= skid_v_next;
            skid_pc_reg   <= skid_pc_next;
            skid_inst_reg <= skid_inst_next;
            id_valid_reg  <= id_valid_next;
            id_pc_reg     <= id_pc_next;
            id_inst_reg   <= id_inst_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A queue-based model tracks which addresses
//   have been fetched but not yet delivered to decode; a compare process checks
//   the DUT against it every cycle, and directed literal checks pin the model.
//   The instruction memory returns addr ^ KEY one cycle after an enabled read.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jump_flag  (jump_flag),
        .jump_target(jump_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ KEY;
    end

    // ---------------------------------------------------------------------
    // Model: next fetch address plus the ordered list of fetched addresses
    // not yet handed to decode. Anything fetched at an earlier edge can move
    // into decode at the next non-stalled edge.
    // ---------------------------------------------------------------------
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_q[$];
    bit          m_valid = 1'b0;
    logic [31:0] m_id_pc = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_valid = 1'b0;
        end else if (jump_flag) begin
            m_q.delete();
            m_q.push_back({jump_target[31:2], 2'b00});
            m_pc = {jump_target[31:2], 2'b00} + 32'd4;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (m_q.size() > 0) begin
                m_valid = 1'b1;
                m_id_pc = m_q.pop_front();
            end else begin
                m_valid = 1'b0;
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic exp_en;
            exp_en = !rst && (jump_flag || !stall);
            check("imem_en", 32'(imem_en), 32'(exp_en));
            if (exp_en)
                check("imem_addr", imem_addr,
                      jump_flag ? {jump_target[31:2], 2'b00} : m_pc);
            check("id_valid", 32'(id_valid), 32'(m_valid));
            if (m_valid) begin
                check("id_pc", id_pc, m_id_pc);
                check("id_inst", id_inst, m_id_pc ^ KEY);
                $display("id pc=%h inst=%h", id_pc, id_inst);
            end else begin
                check("id_inst_nop", id_inst, NOP_INST);
            end
        end
    end

    // Inputs change just after the rising edge; the task returns at the
    // following falling edge so outputs of that cycle can be inspected.
    task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        jump_flag = j;
        jump_target = t;
        @(negedge clk);
    endtask

    logic [31:0] stall_pat = 32'hC3A5_1E69;

    initial begin
        // Reset, two cycles
        drive(1, 0, 0, 0);
        check("rst_en_0", 32'(imem_en), 32'd0);
        drive(1, 0, 0, 0);
        check_en = 1'b1;
        check("rst_en_1", 32'(imem_en), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_inst", id_inst, NOP_INST);

        // 1: sequential stream from RESET_PC
        drive(0, 0, 0, 0);
        check("t1_addr0", imem_addr, 32'h0);
        drive(0, 0, 0, 0);
        check("t1_addr4", imem_addr, 32'h4);
        drive(0, 0, 0, 0);
        check("t1_addr8", imem_addr, 32'h8);
        check("t1_valid", 32'(id_valid), 32'd1);
        check("t1_pc0", id_pc, 32'h0);
        check("t1_inst0", id_inst, 32'hA5A5_0000);
        drive(0, 0, 0, 0);
        check("t1_pc4", id_pc, 32'h4);
        check("t1_inst4", id_inst, 32'hA5A5_0004);
        drive(0, 0, 0, 0);
        check("t1_pc8", id_pc, 32'h8);
        drive(0, 0, 0, 0);
        check("t1_pcC", id_pc, 32'hC);

        // 2: redirect in a steady stream
        drive(0, 0, 1, 32'h100);
        check("t2_addr", imem_addr, 32'h100);
        drive(0, 0, 0, 0);
        check("t2_bubble", 32'(id_valid), 32'd0);
        check("t2_nop", id_inst, NOP_INST);
        drive(0, 0, 0, 0);
        check("t2_pc100", id_pc, 32'h100);
        drive(0, 0, 0, 0);
        check("t2_pc104", id_pc, 32'h104);

        // 3: three-cycle stall while 0x10 is in decode
        drive(0, 0, 1, 32'h10);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        check("t3_pc_at_stall", id_pc, 32'h10);
        check("t3_en0", 32'(imem_en), 32'd0);
        drive(0, 1, 0, 0);
        check("t3_frozen1", id_pc, 32'h10);
        check("t3_en1", 32'(imem_en), 32'd0);
        drive(0, 1, 0, 0);
        check("t3_frozen2", id_pc, 32'h10);
        drive(0, 0, 0, 0);
        check("t3_frozen3", id_pc, 32'h10);
        drive(0, 0, 0, 0);
        check("t3_pc14", id_pc, 32'h14);
        drive(0, 0, 0, 0);
        check("t3_pc18", id_pc, 32'h18);
        drive(0, 0, 0, 0);
        check("t3_pc1C", id_pc, 32'h1C);

        // 4: stall and redirect together, skid already loaded
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 32'h200);
        check("t4_en", 32'(imem_en), 32'd1);
        check("t4_addr", imem_addr, 32'h200);
        drive(0, 0, 0, 0);
        check("t4_bubble", 32'(id_valid), 32'd0);
        drive(0, 0, 0, 0);
        check("t4_pc200", id_pc, 32'h200);
        drive(0, 0, 0, 0);
        check("t4_pc204", id_pc, 32'h204);

        // 5: one-cycle reset with the skid buffer full
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        check("t5_en_rst", 32'(imem_en), 32'd0);
        drive(0, 0, 0, 0);
        check("t5_invalid1", 32'(id_valid), 32'd0);
        check("t5_addr0", imem_addr, RESET_PC);
        drive(0, 0, 0, 0);
        check("t5_invalid2", 32'(id_valid), 32'd0);
        drive(0, 0, 0, 0);
        check("t5_pc0", id_pc, RESET_PC);

        // 6: misaligned target and address wrap
        drive(0, 0, 1, 32'h102);
        check("t6_addr100", imem_addr, 32'h100);
        drive(0, 0, 0, 0);
        check("t6_addr104", imem_addr, 32'h104);
        drive(0, 0, 0, 0);
        check("t6_pc100", id_pc, 32'h100);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0);
        check("t6_addr_wrap", imem_addr, 32'h0);
        drive(0, 0, 0, 0);
        check("t6_pc_top", id_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0);
        check("t6_pc_wrap", id_pc, 32'h0);
        check("t6_inst_wrap", id_inst, 32'hA5A5_0000);

        // Mixed stall/redirect pattern, checked by the model only
        for (int i = 0; i < 32; i++) begin
            if (i % 11 == 5)
                drive(0, stall_pat[i], 1, 32'h300 + 32'(i) * 32'd16);
            else
                drive(0, stall_pat[i], 0, 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
